// File: rtl/mem_request_initiator.sv
// Processor-side memory request initiator: arbitrates fetch/data requests,
// drives the memory strobes, waits for MEM_MFC and reports completion or fault.
module mem_request_initiator #(
    parameter int unsigned TIMEOUT_CYCLES = 15
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic        IF_Req,
    input  logic [31:0] IF_Address,
    output logic        IF_Ack,
    output logic [31:0] IF_Data,
    input  logic        DM_Req,
    input  logic        DM_Write,
    input  logic [31:0] DM_Address,
    input  logic [31:0] DM_Data_Wr,
    output logic        DM_Ack,
    output logic [31:0] DM_Data_Rd,
    output logic        Fault,
    output logic [1:0]  Fault_Code,
    output logic [31:0] Fault_Address,
    output logic        Busy,
    output logic [31:0] MEM_Address,
    output logic [31:0] MEM_Data_In,
    output logic        MEM_Read,
    output logic        MEM_Write,
    input  logic [31:0] MEM_Data_Out,
    input  logic        MEM_MFC,
    input  logic        MEM_ANA_FLAG
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_DONE  = 2'd3
    } state_t;

    localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);
    localparam logic [1:0] CODE_NONE     = 2'b00;
    localparam logic [1:0] CODE_ANA      = 2'b01;
    localparam logic [1:0] CODE_TIMEOUT  = 2'b10;

    state_t      r_state;
    logic        r_is_dm;
    logic        r_write;
    logic [7:0]  r_cnt;
    logic        r_if_ack;
    logic        r_dm_ack;
    logic [31:0] r_if_data;
    logic [31:0] r_dm_data;
    logic        r_fault;
    logic [1:0]  r_fault_code;
    logic [31:0] r_fault_addr;
    logic        r_busy;
    logic [31:0] r_mem_addr;
    logic [31:0] r_mem_wdata;
    logic        r_mem_read;
    logic        r_mem_write;

    always_ff @(posedge Clock) begin
        if (Reset) begin
            r_state      <= S_IDLE;
            r_is_dm      <= 1'b0;
            r_write      <= 1'b0;
            r_cnt        <= 8'd0;
            r_if_ack     <= 1'b0;
            r_dm_ack     <= 1'b0;
            r_if_data    <= 32'd0;
            r_dm_data    <= 32'd0;
            r_fault      <= 1'b0;
            r_fault_code <= CODE_NONE;
            r_fault_addr <= 32'd0;
            r_busy       <= 1'b0;
            r_mem_addr   <= 32'd0;
            r_mem_wdata  <= 32'd0;
            r_mem_read   <= 1'b0;
            r_mem_write  <= 1'b0;
        end else begin
            // Ack and Fault are single-cycle pulses raised only on entry to DONE
            r_if_ack <= 1'b0;
            r_dm_ack <= 1'b0;
            r_fault  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (DM_Req) begin
                        r_is_dm     <= 1'b1;
                        r_write     <= DM_Write;
                        r_mem_addr  <= DM_Address;
                        r_mem_wdata <= DM_Data_Wr;
                        r_mem_read  <= ~DM_Write;
                        r_mem_write <= DM_Write;
                        r_cnt       <= 8'd0;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end else if (IF_Req) begin
                        r_is_dm     <= 1'b0;
                        r_write     <= 1'b0;
                        r_mem_addr  <= IF_Address;
                        r_mem_read  <= 1'b1;
                        r_mem_write <= 1'b0;
                        r_cnt       <= 8'd0;
                        r_busy      <= 1'b1;
                        r_state     <= S_ISSUE;
                    end
                end
                S_ISSUE: begin
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (MEM_MFC) begin
                        if (MEM_ANA_FLAG) begin
                            r_fault_code <= CODE_ANA;
                            r_fault_addr <= r_mem_addr;
                            r_fault      <= 1'b1;
                        end else begin
                            r_fault_code <= CODE_NONE;
                            if (!r_write && r_is_dm)  r_dm_data <= MEM_Data_Out;
                            if (!r_write && !r_is_dm) r_if_data <= MEM_Data_Out;
                        end
                        r_mem_read  <= 1'b0;
                        r_mem_write <= 1'b0;
                        r_dm_ack    <= r_is_dm;
                        r_if_ack    <= ~r_is_dm;
                        r_state     <= S_DONE;
                    end else if (r_cnt >= TIMEOUT_LIMIT) begin
                        r_fault_code <= CODE_TIMEOUT;
                        r_fault_addr <= r_mem_addr;
                        r_fault      <= 1'b1;
                        r_mem_read   <= 1'b0;
                        r_mem_write  <= 1'b0;
                        r_dm_ack     <= r_is_dm;
                        r_if_ack     <= ~r_is_dm;
                        r_state      <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt + 8'd1;
                    end
                end
                S_DONE: begin
                    r_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign IF_Ack        = r_if_ack;
    assign IF_Data       = r_if_data;
    assign DM_Ack        = r_dm_ack;
    assign DM_Data_Rd    = r_dm_data;
    assign Fault         = r_fault;
    assign Fault_Code    = r_fault_code;
    assign Fault_Address = r_fault_addr;
    assign Busy          = r_busy;
    assign MEM_Address   = r_mem_addr;
    assign MEM_Data_In   = r_mem_wdata;
    assign MEM_Read      = r_mem_read;
    assign MEM_Write     = r_mem_write;

endmodule

// File: tb/tb_mem_request_initiator.sv
// Directed self-checking bench for mem_request_initiator (TIMEOUT_CYCLES = 4).
module tb_mem_request_initiator;

    logic        Clock = 1'b0;
    logic        Reset = 1'b1;
    logic        IF_Req = 1'b0;
    logic [31:0] IF_Address = 32'd0;
    logic        IF_Ack;
    logic [31:0] IF_Data;
    logic        DM_Req = 1'b0;
    logic        DM_Write = 1'b0;
    logic [31:0] DM_Address = 32'd0;
    logic [31:0] DM_Data_Wr = 32'd0;
    logic        DM_Ack;
    logic [31:0] DM_Data_Rd;
    logic        Fault;
    logic [1:0]  Fault_Code;
    logic [31:0] Fault_Address;
    logic        Busy;
    logic [31:0] MEM_Address;
    logic [31:0] MEM_Data_In;
    logic        MEM_Read;
    logic        MEM_Write;
    logic [31:0] MEM_Data_Out = 32'd0;
    logic        MEM_MFC = 1'b1;
    logic        MEM_ANA_FLAG = 1'b0;

    int checks = 0;
    int errors = 0;

    mem_request_initiator #(.TIMEOUT_CYCLES(4)) dut (
        .Clock(Clock), .Reset(Reset),
        .IF_Req(IF_Req), .IF_Address(IF_Address), .IF_Ack(IF_Ack), .IF_Data(IF_Data),
        .DM_Req(DM_Req), .DM_Write(DM_Write), .DM_Address(DM_Address),
        .DM_Data_Wr(DM_Data_Wr), .DM_Ack(DM_Ack), .DM_Data_Rd(DM_Data_Rd),
        .Fault(Fault), .Fault_Code(Fault_Code), .Fault_Address(Fault_Address),
        .Busy(Busy), .MEM_Address(MEM_Address), .MEM_Data_In(MEM_Data_In),
        .MEM_Read(MEM_Read), .MEM_Write(MEM_Write), .MEM_Data_Out(MEM_Data_Out),
        .MEM_MFC(MEM_MFC), .MEM_ANA_FLAG(MEM_ANA_FLAG)
    );

    always #5 Clock = ~Clock;

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    task automatic test_reset();
        Reset = 1'b1;
        tick();
        tick();
        checks++; if (IF_Ack !== 1'b0) begin errors++; $display("FAIL rst_if_ack got %0h exp 0", IF_Ack); end
        checks++; if (DM_Ack !== 1'b0) begin errors++; $display("FAIL rst_dm_ack got %0h exp 0", DM_Ack); end
        checks++; if (MEM_Read !== 1'b0 || MEM_Write !== 1'b0) begin errors++; $display("FAIL rst_strobes got %0h%0h exp 00", MEM_Read, MEM_Write); end
        checks++; if (MEM_Address !== 32'd0) begin errors++; $display("FAIL rst_mem_addr got %h exp 0", MEM_Address); end
        checks++; if (Busy !== 1'b0) begin errors++; $display("FAIL rst_busy got %0h exp 0", Busy); end
        checks++; if (Fault_Code !== 2'b00 || Fault !== 1'b0) begin errors++; $display("FAIL rst_fault got %0h/%0h exp 0/0", Fault, Fault_Code); end
        checks++; if (IF_Data !== 32'd0 || DM_Data_Rd !== 32'd0) begin errors++; $display("FAIL rst_data got %h/%h exp 0/0", IF_Data, DM_Data_Rd); end
        Reset = 1'b0;
    endtask

    task automatic test_fetch();
        IF_Address = 32'h0000_0005; MEM_Data_Out = 32'hDEAD_BEEF; IF_Req = 1'b1;
        tick();  // edge 0
        checks++; if (MEM_Read !== 1'b1 || MEM_Write !== 1'b0) begin errors++; $display("FAIL fetch_c1_strobe got %0h%0h exp 10", MEM_Read, MEM_Write); end
        checks++; if (MEM_Address !== 32'h5) begin errors++; $display("FAIL fetch_c1_addr got %h exp 5", MEM_Address); end
        checks++; if (Busy !== 1'b1) begin errors++; $display("FAIL fetch_c1_busy got %0h exp 1", Busy); end
        tick();
        checks++; if (MEM_Read !== 1'b1 || IF_Ack !== 1'b0) begin errors++; $display("FAIL fetch_c2 rd/ack got %0h/%0h exp 1/0", MEM_Read, IF_Ack); end
        tick();
        checks++; if (IF_Ack !== 1'b1 || DM_Ack !== 1'b0) begin errors++; $display("FAIL fetch_c3_ack got %0h/%0h exp 1/0", IF_Ack, DM_Ack); end
        checks++; if (IF_Data !== 32'hDEAD_BEEF) begin errors++; $display("FAIL fetch_data got %h exp deadbeef", IF_Data); end
        checks++; if (Fault !== 1'b0 || MEM_Read !== 1'b0) begin errors++; $display("FAIL fetch_c3 fault/rd got %0h/%0h exp 0/0", Fault, MEM_Read); end
        IF_Req = 1'b0;
        tick();
        checks++; if (IF_Ack !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL fetch_c4 ack/busy got %0h/%0h exp 0/0", IF_Ack, Busy); end
    endtask

    task automatic test_store();
        DM_Write = 1'b1; DM_Address = 32'h0000_0041; DM_Data_Wr = 32'h1234_5678; DM_Req = 1'b1;
        tick();
        checks++; if (MEM_Write !== 1'b1 || MEM_Read !== 1'b0) begin errors++; $display("FAIL store_c1_strobe got wr%0h rd%0h exp wr1 rd0", MEM_Write, MEM_Read); end
        checks++; if (MEM_Data_In !== 32'h1234_5678 || MEM_Address !== 32'h41) begin errors++; $display("FAIL store_c1_bus got %h@%h exp 12345678@41", MEM_Data_In, MEM_Address); end
        tick();
        checks++; if (MEM_Write !== 1'b1 || MEM_Read !== 1'b0 || DM_Ack !== 1'b0) begin errors++; $display("FAIL store_c2 got wr%0h rd%0h ack%0h exp 1 0 0", MEM_Write, MEM_Read, DM_Ack); end
        tick();
        checks++; if (DM_Ack !== 1'b1 || Fault !== 1'b0 || MEM_Write !== 1'b0) begin errors++; $display("FAIL store_c3 got ack%0h f%0h wr%0h exp 1 0 0", DM_Ack, Fault, MEM_Write); end
        DM_Req = 1'b0; DM_Write = 1'b0;
        tick();
    endtask

    task automatic test_priority();
        DM_Address = 32'h0000_0040; IF_Address = 32'h0000_0001;
        MEM_Data_Out = 32'hAAAA_5555; DM_Req = 1'b1; IF_Req = 1'b1;
        tick();  // edge 0
        checks++; if (MEM_Address !== 32'h40 || MEM_Read !== 1'b1) begin errors++; $display("FAIL prio_c1 got %h rd%0h exp 40 rd1", MEM_Address, MEM_Read); end
        tick();
        tick();  // cycle 3
        checks++; if (DM_Ack !== 1'b1 || IF_Ack !== 1'b0) begin errors++; $display("FAIL prio_c3_ack got dm%0h if%0h exp dm1 if0", DM_Ack, IF_Ack); end
        checks++; if (DM_Data_Rd !== 32'hAAAA_5555) begin errors++; $display("FAIL prio_load_data got %h exp aaaa5555", DM_Data_Rd); end
        DM_Req = 1'b0; MEM_Data_Out = 32'h0BAD_F00D;
        tick();  // edge 3, back to IDLE
        tick();  // edge 4, fetch accepted
        checks++; if (MEM_Address !== 32'h1 || MEM_Read !== 1'b1) begin errors++; $display("FAIL prio_c5 got %h rd%0h exp 1 rd1", MEM_Address, MEM_Read); end
        tick();
        checks++; if (IF_Ack !== 1'b0) begin errors++; $display("FAIL prio_c6_ack got %0h exp 0", IF_Ack); end
        tick();  // cycle 7
        checks++; if (IF_Ack !== 1'b1 || IF_Data !== 32'h0BAD_F00D) begin errors++; $display("FAIL prio_c7 got ack%0h %h exp ack1 0badf00d", IF_Ack, IF_Data); end
        checks++; if (DM_Data_Rd !== 32'hAAAA_5555) begin errors++; $display("FAIL prio_dm_hold got %h exp aaaa5555", DM_Data_Rd); end
        IF_Req = 1'b0;
        tick();
    endtask

    task automatic test_unassigned();
        DM_Address = 32'h0000_0100; MEM_Data_Out = 32'h9999_9999; MEM_ANA_FLAG = 1'b1; DM_Req = 1'b1;
        tick();
        tick();
        tick();
        checks++; if (DM_Ack !== 1'b1 || Fault !== 1'b1) begin errors++; $display("FAIL ana_ack got ack%0h f%0h exp 1 1", DM_Ack, Fault); end
        checks++; if (Fault_Code !== 2'b01 || Fault_Address !== 32'h100) begin errors++; $display("FAIL ana_code got %0h@%h exp 1@100", Fault_Code, Fault_Address); end
        checks++; if (DM_Data_Rd !== 32'hAAAA_5555) begin errors++; $display("FAIL ana_data got %h exp aaaa5555", DM_Data_Rd); end
        DM_Req = 1'b0; MEM_ANA_FLAG = 1'b0;
        tick();
        checks++; if (Fault !== 1'b0 || Fault_Code !== 2'b01) begin errors++; $display("FAIL ana_after got f%0h c%0h exp 0 1", Fault, Fault_Code); end
    endtask

    task automatic test_timeout();
        MEM_MFC = 1'b0; IF_Address = 32'h0000_0200; IF_Req = 1'b1;
        tick();  // edge 0
        checks++; if (MEM_Read !== 1'b1) begin errors++; $display("FAIL to_c1_rd got %0h exp 1", MEM_Read); end
        for (int i = 2; i <= 6; i++) begin
            tick();
            checks++; if (IF_Ack !== 1'b0 || MEM_Read !== 1'b1) begin errors++; $display("FAIL to_wait_c%0d got ack%0h rd%0h exp 0 1", i, IF_Ack, MEM_Read); end
        end
        tick();  // cycle 7
        checks++; if (IF_Ack !== 1'b1 || Fault !== 1'b1) begin errors++; $display("FAIL to_c7_ack got ack%0h f%0h exp 1 1", IF_Ack, Fault); end
        checks++; if (Fault_Code !== 2'b10 || Fault_Address !== 32'h200) begin errors++; $display("FAIL to_code got %0h@%h exp 2@200", Fault_Code, Fault_Address); end
        checks++; if (MEM_Read !== 1'b0 || IF_Data !== 32'h0BAD_F00D) begin errors++; $display("FAIL to_c7 rd%0h data %h exp rd0 0badf00d", MEM_Read, IF_Data); end
        IF_Req = 1'b0;
        tick();
        checks++; if (MEM_Read !== 1'b0 || IF_Ack !== 1'b0 || Busy !== 1'b0) begin errors++; $display("FAIL to_c8 got rd%0h ack%0h busy%0h exp 0 0 0", MEM_Read, IF_Ack, Busy); end
        MEM_MFC = 1'b1;
    endtask

    task automatic test_reset_mid();
        MEM_MFC = 1'b0; DM_Address = 32'h0000_0044; DM_Req = 1'b1;
        tick();
        tick();  // now in WAIT
        Reset = 1'b1;
        tick();
        checks++; if (MEM_Read !== 1'b0 || Busy !== 1'b0 || DM_Ack !== 1'b0) begin errors++; $display("FAIL rmid_outs got rd%0h busy%0h ack%0h exp 0 0 0", MEM_Read, Busy, DM_Ack); end
        checks++; if (Fault_Code !== 2'b00 || Fault_Address !== 32'd0 || MEM_Address !== 32'd0) begin errors++; $display("FAIL rmid_fault got %0h %h %h exp 0 0 0", Fault_Code, Fault_Address, MEM_Address); end
        checks++; if (DM_Data_Rd !== 32'd0 || IF_Data !== 32'd0) begin errors++; $display("FAIL rmid_data got %h %h exp 0 0", DM_Data_Rd, IF_Data); end
        MEM_MFC = 1'b1; MEM_Data_Out = 32'h55AA_55AA;
        tick();
        checks++; if (DM_Ack !== 1'b0 || MEM_Read !== 1'b0) begin errors++; $display("FAIL rmid_hold got ack%0h rd%0h exp 0 0", DM_Ack, MEM_Read); end
        Reset = 1'b0;
        tick();  // first edge after release re-accepts the held request
        checks++; if (MEM_Read !== 1'b1 || MEM_Address !== 32'h44 || Busy !== 1'b1) begin errors++; $display("FAIL rmid_restart got rd%0h %h busy%0h exp 1 44 1", MEM_Read, MEM_Address, Busy); end
        tick();
        checks++; if (DM_Ack !== 1'b0) begin errors++; $display("FAIL rmid_early_ack got %0h exp 0", DM_Ack); end
        tick();
        checks++; if (DM_Ack !== 1'b1 || DM_Data_Rd !== 32'h55AA_55AA || Fault_Code !== 2'b00) begin errors++; $display("FAIL rmid_ack got ack%0h %h c%0h exp 1 55aa55aa 0", DM_Ack, DM_Data_Rd, Fault_Code); end
        DM_Req = 1'b0;
        tick();
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_priority();
        test_unassigned();
        test_timeout();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
